// File: rtl/apb_master_if.sv
// Bundle of the command/response side and the APB bus side of apb_master.
// The master modport is the bridge's view; slave is the view of whoever drives commands and completes APB.
interface apb_master_if #(
   parameter int ADDR_WD = 8,
   parameter int DATA_WD = 32
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_write;
   logic [ADDR_WD-1:0] cmd_addr;
   logic [DATA_WD-1:0] cmd_wdata;

   logic               rsp_valid;
   logic [DATA_WD-1:0] rsp_rdata;
   logic               rsp_err;

   logic               PSEL;
   logic               PENABLE;
   logic               PWRITE;
   logic [ADDR_WD-1:0] PADDR;
   logic [DATA_WD-1:0] PWDATA;
   logic [DATA_WD-1:0] PRDATA;
   logic               PREADY;
   logic               PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_master.sv
// Command-to-APB bridge: IDLE/SETUP/ACCESS FSM with registered APB outputs and a one-cycle response pulse.
// Defining APB_TIMEOUT_EN adds a wait-state watchdog that ends a transfer after TIMEOUT_CYC stalled ACCESS cycles.
module apb_master #(
   parameter int ADDR_WD     = 8,
   parameter int DATA_WD     = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input logic         PCLK,
   input logic         PRESETn,
   apb_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   state_e             state_q;
   logic               psel_q;
   logic               penable_q;
   logic               pwrite_q;
   logic [ADDR_WD-1:0] paddr_q;
   logic [DATA_WD-1:0] pwdata_q;
   logic               rspValid_q;
   logic [DATA_WD-1:0] rspRdata_q;
   logic               rspErr_q;
   logic               accept;
   logic               timeoutHit;

   // Held low during reset so nothing can be accepted until PRESETn is released.
   assign bus.cmd_ready = PRESETn &&
                          ((state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY));
   assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef APB_TIMEOUT_EN
   localparam int CntWd = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CntWd-1:0] CntLast = CntWd'(TIMEOUT_CYC - 1);

   logic [CntWd-1:0] waitCnt_q;

   assign timeoutHit = (state_q == ACCESS) && !bus.PREADY && (waitCnt_q == CntLast);

   // Counts consecutive stalled ACCESS cycles; any other cycle restarts the count.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         waitCnt_q <= '0;
      end else if ((state_q != ACCESS) || bus.PREADY || timeoutHit) begin
         waitCnt_q <= '0;
      end else begin
         waitCnt_q <= waitCnt_q + 1'b1;
      end
   end
`else
   assign timeoutHit = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         rspValid_q <= 1'b0;
         rspRdata_q <= '0;
         rspErr_q   <= 1'b0;
      end else begin
         rspValid_q <= 1'b0;

         // Acceptance only happens in IDLE or at a completing ACCESS edge, so latching here covers both.
         if (accept) begin
            pwrite_q <= bus.cmd_write;
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
         end

         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q   <= SETUP;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
            end
            ACCESS: begin
               if (bus.PREADY) begin
                  rspValid_q <= 1'b1;
                  rspRdata_q <= pwrite_q ? '0 : bus.PRDATA;
                  rspErr_q   <= bus.PSLVERR;
                  penable_q  <= 1'b0;
                  if (accept) begin
                     state_q <= SETUP;
                  end else begin
                     state_q <= IDLE;
                     psel_q  <= 1'b0;
                  end
               end else if (timeoutHit) begin
                  rspValid_q <= 1'b1;
                  rspRdata_q <= '0;
                  rspErr_q   <= 1'b1;
                  state_q    <= IDLE;
                  psel_q     <= 1'b0;
                  penable_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.PSEL      = psel_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_rdata = rspRdata_q;
   assign bus.rsp_err   = rspErr_q;
endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed protocol scenarios followed by randomized traffic,
// all compared against a cycle-counting transaction model; define APB_TIMEOUT_EN to cover the watchdog build.
module tb_apb_master;
   localparam int ADDR_WD     = 8;
   localparam int DATA_WD     = 32;
   localparam int TIMEOUT_CYC = 4;

   logic PCLK    = 1'b0;
   logic PRESETn = 1'b0;

   apb_master_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD)) bus ();

   apb_master #(
      .ADDR_WD    (ADDR_WD),
      .DATA_WD    (DATA_WD),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .PCLK   (PCLK),
      .PRESETn(PRESETn),
      .bus    (bus)
   );

   always #5 PCLK = ~PCLK;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: whether a transfer is in flight, how many cycles since it was accepted,
   // how many consecutive stalled access cycles it has seen, and the values the bus should show.
   bit                 busy;
   int                 age;
   int                 stallCnt;
   bit                 expWrite;
   logic [ADDR_WD-1:0] expAddr;
   logic [DATA_WD-1:0] expWdata;
   bit                 expRspValid;
   logic [DATA_WD-1:0] expRdata;
   bit                 expErr;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic startTxn(input bit write, input logic [ADDR_WD-1:0] addr, input logic [DATA_WD-1:0] wdata);
      busy     = 1'b1;
      age      = 0;
      stallCnt = 0;
      expWrite = write;
      expAddr  = addr;
      expWdata = write ? wdata : '0;
   endtask

   task automatic clearModel();
      busy        = 1'b0;
      age         = 0;
      stallCnt    = 0;
      expWrite    = 1'b0;
      expAddr     = '0;
      expWdata    = '0;
      expRspValid = 1'b0;
      expRdata    = '0;
      expErr      = 1'b0;
   endtask

   // Called just after a falling edge: checks registered outputs, drives one cycle of inputs,
   // predicts the effect of the coming rising edge and returns at the next falling edge.
   task automatic applyStimulus(input bit valid, input bit write, input logic [ADDR_WD-1:0] addr,
                                input logic [DATA_WD-1:0] wdata, input bit ready,
                                input logic [DATA_WD-1:0] rdata, input bit slverr);
      checkOutput("PSEL", bus.PSEL, busy);
      checkOutput("PENABLE", bus.PENABLE, busy && (age >= 1));
      checkOutput("PADDR", bus.PADDR, expAddr);
      checkOutput("PWRITE", bus.PWRITE, expWrite);
      checkOutput("PWDATA", bus.PWDATA, expWdata);
      checkOutput("rsp_valid", bus.rsp_valid, expRspValid);
      checkOutput("rsp_rdata", bus.rsp_rdata, expRdata);
      checkOutput("rsp_err", bus.rsp_err, expErr);

      bus.cmd_valid = valid;
      bus.cmd_write = write;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.PREADY    = ready;
      bus.PRDATA    = rdata;
      bus.PSLVERR   = slverr;
      #1;
      checkOutput("cmd_ready", bus.cmd_ready, !busy || ((age >= 1) && ready));

      expRspValid = 1'b0;
      if (!busy) begin
         if (valid) startTxn(write, addr, wdata);
      end else if (age == 0) begin
         age++;
      end else if (ready) begin
         expRspValid = 1'b1;
         expRdata    = expWrite ? '0 : rdata;
         expErr      = slverr;
         if (valid) startTxn(write, addr, wdata);
         else busy = 1'b0;
      end else begin
         age++;
         stallCnt++;
`ifdef APB_TIMEOUT_EN
         if (stallCnt == TIMEOUT_CYC) begin
            busy        = 1'b0;
            expRspValid = 1'b1;
            expRdata    = '0;
            expErr      = 1'b1;
         end
`endif
      end

      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   // Asserts reset part-way through the low clock phase, checks the asynchronous clear,
   // and releases it exactly on a falling edge so the very next rising edge may accept.
   task automatic applyReset();
      bus.cmd_valid = 1'b0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      #2;
      PRESETn = 1'b0;
      #1;
      checkOutput("rst PSEL", bus.PSEL, 1'b0);
      checkOutput("rst PENABLE", bus.PENABLE, 1'b0);
      checkOutput("rst PWRITE", bus.PWRITE, 1'b0);
      checkOutput("rst PADDR", bus.PADDR, '0);
      checkOutput("rst PWDATA", bus.PWDATA, '0);
      checkOutput("rst rsp_valid", bus.rsp_valid, 1'b0);
      checkOutput("rst rsp_rdata", bus.rsp_rdata, '0);
      checkOutput("rst rsp_err", bus.rsp_err, 1'b0);
      checkOutput("rst cmd_ready", bus.cmd_ready, 1'b0);
      clearModel();
      @(negedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
   endtask

   task automatic idleCycle(input bit ready);
      applyStimulus(1'b0, 1'b0, '0, '0, ready, $urandom, 1'b0);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.PRDATA    = '0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      clearModel();

      @(negedge PCLK);
      applyReset();

      // Zero-wait write: SETUP then ACCESS then a response pulse two edges after acceptance.
      applyStimulus(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b1, '0, 1'b0);
      checkOutput("wr setup PSEL", bus.PSEL, 1'b1);
      checkOutput("wr setup PENABLE", bus.PENABLE, 1'b0);
      checkOutput("wr setup PADDR", bus.PADDR, 8'h10);
      idleCycle(1'b1);
      checkOutput("wr access PENABLE", bus.PENABLE, 1'b1);
      checkOutput("wr access PWDATA", bus.PWDATA, 32'hDEADBEEF);
      idleCycle(1'b1);
      checkOutput("wr rsp_valid", bus.rsp_valid, 1'b1);
      checkOutput("wr rsp_rdata", bus.rsp_rdata, 32'h0);
      checkOutput("wr rsp_err", bus.rsp_err, 1'b0);
      idleCycle(1'b1);

      // Read with three wait states; PSLVERR is asserted during the stalls and must be ignored.
      applyStimulus(1'b1, 1'b0, 8'h20, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
      checkOutput("rd PWDATA zero", bus.PWDATA, 32'h0);
      idleCycle(1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 8'hAA, 32'h5555_5555, 1'b0, $urandom, 1'b1);
         checkOutput("rd wait PADDR", bus.PADDR, 8'h20);
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'h12345678, 1'b0);
      checkOutput("rd rsp_rdata", bus.rsp_rdata, 32'h12345678);
      checkOutput("rd rsp_err", bus.rsp_err, 1'b0);
      idleCycle(1'b0);

      // Completer error on a read.
      applyStimulus(1'b1, 1'b0, 8'h44, '0, 1'b1, '0, 1'b0);
      idleCycle(1'b1);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'hCAFE0001, 1'b1);
      checkOutput("slverr rsp_err", bus.rsp_err, 1'b1);
      checkOutput("slverr rsp_rdata", bus.rsp_rdata, 32'hCAFE0001);
      idleCycle(1'b0);

      // Back-to-back: second command accepted on the first transfer's completing edge.
      applyStimulus(1'b1, 1'b1, 8'h01, 32'h0000_0001, 1'b1, '0, 1'b0);
      idleCycle(1'b1);
      applyStimulus(1'b1, 1'b0, 8'h02, '0, 1'b1, '0, 1'b0);
      checkOutput("b2b PSEL held", bus.PSEL, 1'b1);
      checkOutput("b2b second setup", bus.PENABLE, 1'b0);
      checkOutput("b2b first rsp", bus.rsp_valid, 1'b1);
      idleCycle(1'b1);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'hB2B0_0002, 1'b0);
      checkOutput("b2b second rsp", bus.rsp_valid, 1'b1);
      checkOutput("b2b second rdata", bus.rsp_rdata, 32'hB2B0_0002);
      idleCycle(1'b0);

      // Reset during ACCESS of a write aborts it without a response; the next command runs normally.
      applyStimulus(1'b1, 1'b1, 8'h30, 32'h3030_3030, 1'b0, '0, 1'b0);
      idleCycle(1'b0);
      idleCycle(1'b0);
      applyReset();
      applyStimulus(1'b1, 1'b1, 8'h31, 32'h3131_3131, 1'b1, '0, 1'b0);
      idleCycle(1'b1);
      idleCycle(1'b1);
      checkOutput("post-rst rsp_valid", bus.rsp_valid, 1'b1);
      idleCycle(1'b0);

      // PREADY held low: the watchdog build terminates with an error, otherwise ACCESS persists.
      applyStimulus(1'b1, 1'b0, 8'h55, '0, 1'b0, '0, 1'b0);
      idleCycle(1'b0);
      for (int i = 0; i < 100; i++) idleCycle(1'b0);
`ifdef APB_TIMEOUT_EN
      checkOutput("timeout PSEL", bus.PSEL, 1'b0);
      checkOutput("timeout rsp_err", bus.rsp_err, 1'b1);
`else
      checkOutput("stall PSEL", bus.PSEL, 1'b1);
      checkOutput("stall PENABLE", bus.PENABLE, 1'b1);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'h0000_0055, 1'b0);
      checkOutput("stall rsp_rdata", bus.rsp_rdata, 32'h0000_0055);
`endif
      idleCycle(1'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            applyReset();
         end else begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), ADDR_WD'($urandom), $urandom,
                          $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end
endmodule
